// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch window sequencer: boot, redirect, advance and halt control of the PC window
//
// Purpose: decides each cycle whether the program counter window is reloaded
// and with which base. Redirects (trap, branch) go through a one-cycle FLUSH
// state in which no slot is valid. In RUN the window advances by the number of
// slots the backend issued, capped at the window size.
//
// Ports:
//   FS_CLK        in   clock, rising edge
//   FS_RST_N      in   asynchronous active-low reset
//   FS_STALL      in   backend cannot accept the window this cycle
//   FS_ISSUE_CNT  in   slots consumed by issue this cycle
//   FS_BR_VALID   in   taken branch/jump redirect request
//   FS_BR_TARGET  in   redirect target address
//   FS_TRAP_VALID in   trap/interrupt request
//   FS_TRAP_VEC   in   trap handler address
//   FS_HALT       in   request to stop fetching
//   PC_LD         out  load strobe to the PC window (combinational)
//   PC_IN         out  new window base presented with PC_LD (combinational)
//   FS_WIN_VALID  out  per-slot valid for the current window (combinational)
//   FS_MISALIGN   out  pulse: branch target misaligned (combinational)
//   FS_BASE       out  registered copy of the current window base
//   FS_STATE      out  BOOT=0, RUN=1, FLUSH=2, HALTED=3
module fetch_sequencer #(
  parameter int          INSTR_WINDOW = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                                FS_CLK,
  input  logic                                FS_RST_N,
  input  logic                                FS_STALL,
  input  logic [$clog2(INSTR_WINDOW+1)-1:0]   FS_ISSUE_CNT,
  input  logic                                FS_BR_VALID,
  input  logic [31:0]                         FS_BR_TARGET,
  input  logic                                FS_TRAP_VALID,
  input  logic [31:0]                         FS_TRAP_VEC,
  input  logic                                FS_HALT,
  output logic                                PC_LD,
  output logic [31:0]                         PC_IN,
  output logic [INSTR_WINDOW-1:0]             FS_WIN_VALID,
  output logic                                FS_MISALIGN,
  output logic [31:0]                         FS_BASE,
  output logic [1:0]                          FS_STATE
);

  localparam int CNT_W = $clog2(INSTR_WINDOW + 1);
  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(INSTR_WINDOW);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_FLUSH  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] base;

  logic [CNT_W-1:0] issue_eff;
  logic [31:0]      step;
  logic [31:0]      trap_base;

  // Trap vectors are word-aligned by dropping the low bits, never faulted.
  assign trap_base = {FS_TRAP_VEC[31:2], 2'b00};

  // Over-reported issue counts are clamped to the window; the sum wraps mod 2^32.
  assign issue_eff = (FS_ISSUE_CNT > WIN_CNT) ? WIN_CNT : FS_ISSUE_CNT;
  assign step      = 32'(issue_eff) << 2;

  logic unused_trap_lsbs;
  assign unused_trap_lsbs = ^FS_TRAP_VEC[1:0];

  always_comb begin
    state_next   = state;
    PC_LD        = 1'b0;
    PC_IN        = base;
    FS_WIN_VALID = '0;
    FS_MISALIGN  = 1'b0;
    unique case (state)
      S_BOOT: begin
        PC_LD      = 1'b1;
        PC_IN      = RESET_VECTOR;
        state_next = S_FLUSH;
      end
      S_RUN: begin
        FS_WIN_VALID = '1;
        if (FS_TRAP_VALID) begin
          PC_LD      = 1'b1;
          PC_IN      = trap_base;
          state_next = S_FLUSH;
        end else if (FS_BR_VALID) begin
          // A misaligned target is routed to the trap handler instead.
          PC_LD       = 1'b1;
          state_next  = S_FLUSH;
          if (FS_BR_TARGET[1:0] == 2'b00) begin
            PC_IN = FS_BR_TARGET;
          end else begin
            PC_IN       = trap_base;
            FS_MISALIGN = 1'b1;
          end
        end else if (FS_HALT) begin
          state_next = S_HALTED;
        end else if (!FS_STALL && (issue_eff != '0)) begin
          PC_LD = 1'b1;
          PC_IN = base + step;
        end
      end
      S_FLUSH: begin
        // Only a trap can re-redirect during flush; it keeps us in FLUSH.
        if (FS_TRAP_VALID) begin
          PC_LD = 1'b1;
          PC_IN = trap_base;
        end else begin
          state_next = S_RUN;
        end
      end
      S_HALTED: begin
        state_next = S_HALTED;
      end
      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge FS_CLK or negedge FS_RST_N) begin
    if (!FS_RST_N) begin
      state <= S_BOOT;
      base  <= RESET_VECTOR;
    end else begin
      state <= state_next;
      if (PC_LD) begin
        base <= PC_IN;
      end
    end
  end

  assign FS_BASE  = base;
  assign FS_STATE = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
  localparam int          W  = 4;
  localparam int          CW = $clog2(W + 1);
  localparam logic [31:0] RV = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic [CW-1:0] cnt;
  logic          br_v;
  logic [31:0]   br_t;
  logic          trap_v;
  logic [31:0]   trap_vec;
  logic          halt;
  logic          pc_ld;
  logic [31:0]   pc_in;
  logic [W-1:0]  wv;
  logic          mis;
  logic [31:0]   base;
  logic [1:0]    st;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.INSTR_WINDOW(W), .RESET_VECTOR(RV)) dut (
    .FS_CLK(clk), .FS_RST_N(rst_n), .FS_STALL(stall), .FS_ISSUE_CNT(cnt),
    .FS_BR_VALID(br_v), .FS_BR_TARGET(br_t), .FS_TRAP_VALID(trap_v),
    .FS_TRAP_VEC(trap_vec), .FS_HALT(halt), .PC_LD(pc_ld), .PC_IN(pc_in),
    .FS_WIN_VALID(wv), .FS_MISALIGN(mis), .FS_BASE(base), .FS_STATE(st)
  );

  task automatic idle();
    stall = 0; cnt = '0; br_v = 0; br_t = '0; trap_v = 0; trap_vec = '0; halt = 0;
  endtask

  // From RUN: branch to b, sit through FLUSH, return at RUN with base b.
  task automatic goto_base(input logic [31:0] b);
    idle(); br_v = 1; br_t = b;
    @(negedge clk); idle();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); rst_n = 1; #2; rst_n = 0; #1;
    checks++;
    if ({st, pc_ld, pc_in, wv, mis, base} !== {2'd0, 1'b1, RV, 4'h0, 1'b0, RV}) begin
      failures++;
      $display("FAIL reset_outputs got st=%0d ld=%0b pc=%h wv=%h mis=%0b base=%h exp st=0 ld=1 pc=%h wv=0 mis=0 base=%h",
               st, pc_ld, pc_in, wv, mis, base, RV, RV);
    end
  endtask

  task automatic test_boot();
    @(negedge clk); rst_n = 1; idle(); #1;
    checks++;
    if ({st, pc_ld, pc_in, wv} !== {2'd0, 1'b1, RV, 4'h0}) begin
      failures++; $display("FAIL boot got st=%0d ld=%0b pc=%h wv=%h exp st=0 ld=1 pc=%h wv=0", st, pc_ld, pc_in, wv, RV);
    end
    @(negedge clk); #1;
    checks++;
    if ({st, pc_ld, wv, base} !== {2'd2, 1'b0, 4'h0, RV}) begin
      failures++; $display("FAIL boot_flush got st=%0d ld=%0b wv=%h base=%h exp st=2 ld=0 wv=0 base=%h", st, pc_ld, wv, base, RV);
    end
    @(negedge clk); #1;
    checks++;
    if ({st, pc_ld, wv, base} !== {2'd1, 1'b0, 4'hF, 32'h0}) begin
      failures++; $display("FAIL boot_run got st=%0d ld=%0b wv=%h base=%h exp st=1 ld=0 wv=f base=0", st, pc_ld, wv, base);
    end
  endtask

  task automatic test_advance();
    goto_base(32'h100);
    cnt = 3; #1;
    checks++;
    if ({pc_ld, pc_in} !== {1'b1, 32'h10C}) begin
      failures++; $display("FAIL adv_cnt3 got ld=%0b pc=%h exp ld=1 pc=0000010c", pc_ld, pc_in);
    end
    @(negedge clk); cnt = 7; #1;
    checks++;
    if ({pc_ld, pc_in, base} !== {1'b1, 32'h11C, 32'h10C}) begin
      failures++; $display("FAIL adv_cnt7 got ld=%0b pc=%h base=%h exp ld=1 pc=0000011c base=0000010c", pc_ld, pc_in, base);
    end
    @(negedge clk); cnt = 0; #1;
    checks++;
    if ({pc_ld, base} !== {1'b0, 32'h11C}) begin
      failures++; $display("FAIL adv_cnt0 got ld=%0b base=%h exp ld=0 base=0000011c", pc_ld, base);
    end
    goto_base(32'hFFFF_FFF8);
    cnt = 4; #1;
    checks++;
    if ({pc_ld, pc_in} !== {1'b1, 32'h8}) begin
      failures++; $display("FAIL adv_wrap got ld=%0b pc=%h exp ld=1 pc=00000008", pc_ld, pc_in);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if ({st, base} !== {2'd1, 32'h8}) begin
      failures++; $display("FAIL adv_wrap_base got st=%0d base=%h exp st=1 base=00000008", st, base);
    end
  endtask

  task automatic test_trap_over_branch();
    trap_v = 1; br_v = 1; br_t = 32'h400; trap_vec = 32'h203; #1;
    checks++;
    if ({pc_ld, pc_in, mis} !== {1'b1, 32'h200, 1'b0}) begin
      failures++; $display("FAIL trap_prio got ld=%0b pc=%h mis=%0b exp ld=1 pc=00000200 mis=0", pc_ld, pc_in, mis);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if ({st, wv, base} !== {2'd2, 4'h0, 32'h200}) begin
      failures++; $display("FAIL trap_flush got st=%0d wv=%h base=%h exp st=2 wv=0 base=00000200", st, wv, base);
    end
    @(negedge clk); #1;
    checks++;
    if ({st, wv} !== {2'd1, 4'hF}) begin
      failures++; $display("FAIL trap_run got st=%0d wv=%h exp st=1 wv=f", st, wv);
    end
  endtask

  task automatic test_misalign();
    br_v = 1; br_t = 32'h402; trap_vec = 32'h300; #1;
    checks++;
    if ({pc_ld, pc_in, mis} !== {1'b1, 32'h300, 1'b1}) begin
      failures++; $display("FAIL misalign got ld=%0b pc=%h mis=%0b exp ld=1 pc=00000300 mis=1", pc_ld, pc_in, mis);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if ({st, mis, base} !== {2'd2, 1'b0, 32'h300}) begin
      failures++; $display("FAIL misalign_pulse got st=%0d mis=%0b base=%h exp st=2 mis=0 base=00000300", st, mis, base);
    end
    @(negedge clk);
    stall = 1; br_v = 1; br_t = 32'h400; #1;
    checks++;
    if ({st, pc_ld, pc_in, mis} !== {2'd1, 1'b1, 32'h400, 1'b0}) begin
      failures++; $display("FAIL br_over_stall got st=%0d ld=%0b pc=%h mis=%0b exp st=1 ld=1 pc=00000400 mis=0", st, pc_ld, pc_in, mis);
    end
    @(negedge clk); idle();
    @(negedge clk); #1;
  endtask

  task automatic test_stall_halt();
    stall = 1; cnt = 2; #1;
    checks++;
    if (pc_ld !== 1'b0) begin
      failures++; $display("FAIL stall_ld got ld=%0b exp ld=0", pc_ld);
    end
    @(negedge clk); #1;
    checks++;
    if ({st, wv, base} !== {2'd1, 4'hF, 32'h400}) begin
      failures++; $display("FAIL stall_hold got st=%0d wv=%h base=%h exp st=1 wv=f base=00000400", st, wv, base);
    end
    idle(); halt = 1; cnt = 2; #1;
    checks++;
    if (pc_ld !== 1'b0) begin
      failures++; $display("FAIL halt_ld got ld=%0b exp ld=0", pc_ld);
    end
    @(negedge clk); idle(); trap_v = 1; trap_vec = 32'h500; br_v = 1; br_t = 32'h600; #1;
    checks++;
    if ({st, pc_ld, wv} !== {2'd3, 1'b0, 4'h0}) begin
      failures++; $display("FAIL halted got st=%0d ld=%0b wv=%h exp st=3 ld=0 wv=0", st, pc_ld, wv);
    end
    @(negedge clk); #1;
    checks++;
    if ({st, base} !== {2'd3, 32'h400}) begin
      failures++; $display("FAIL halted_stay got st=%0d base=%h exp st=3 base=00000400", st, base);
    end
    rst_n = 0; #1;
    checks++;
    if ({st, base, pc_in} !== {2'd0, RV, RV}) begin
      failures++; $display("FAIL halt_reset got st=%0d base=%h pc=%h exp st=0 base=%h pc=%h", st, base, pc_in, RV, RV);
    end
    @(negedge clk); rst_n = 1; idle();
    @(negedge clk); @(negedge clk); #1;
  endtask

  task automatic test_async_reset();
    br_v = 1; br_t = 32'h600;
    @(negedge clk); idle(); #1;
    #2; rst_n = 0; #1;
    checks++;
    if ({st, pc_ld, pc_in, wv, mis, base} !== {2'd0, 1'b1, RV, 4'h0, 1'b0, RV}) begin
      failures++;
      $display("FAIL async_reset got st=%0d ld=%0b pc=%h wv=%h mis=%0b base=%h exp st=0 ld=1 pc=%h wv=0 mis=0 base=%h",
               st, pc_ld, pc_in, wv, mis, base, RV, RV);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({st, base} !== {2'd1, RV}) begin
      failures++; $display("FAIL async_reset_run got st=%0d base=%h exp st=1 base=%h", st, base, RV);
    end
  endtask

  // Reference model: state numbers follow the published encoding; outputs are
  // derived from the behavioural rules using plain arithmetic.
  task automatic test_random();
    int          m_s = 1;
    logic [31:0] m_b = RV;
    int          ns;
    int          n;
    logic        e_ld, e_mis;
    logic [31:0] e_pc;
    logic [W-1:0] e_wv;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst_n    = ($urandom_range(0, 39) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      cnt      = CW'($urandom_range(0, (1 << CW) - 1));
      br_v     = ($urandom_range(0, 4) == 0);
      br_t     = $urandom;
      if ($urandom_range(0, 1) == 0) br_t[1:0] = 2'b00;
      trap_v   = ($urandom_range(0, 7) == 0);
      trap_vec = $urandom;
      halt     = ($urandom_range(0, 29) == 0);
      #1;
      if (!rst_n) begin m_s = 0; m_b = RV; end
      ns = m_s; e_ld = 0; e_pc = m_b; e_wv = '0; e_mis = 0;
      case (m_s)
        0: begin e_ld = 1; e_pc = RV; ns = 2; end
        1: begin
          e_wv = '1;
          n = (int'(cnt) < W) ? int'(cnt) : W;
          if (trap_v) begin e_ld = 1; e_pc = trap_vec - (trap_vec % 4); ns = 2; end
          else if (br_v && (br_t % 4 == 0)) begin e_ld = 1; e_pc = br_t; ns = 2; end
          else if (br_v) begin e_ld = 1; e_pc = trap_vec - (trap_vec % 4); e_mis = 1; ns = 2; end
          else if (halt) ns = 3;
          else if (stall) ns = 1;
          else if (n > 0) begin e_ld = 1; e_pc = 32'((longint'(m_b) + 4 * n) % 64'h1_0000_0000); end
        end
        2: begin
          if (trap_v) begin e_ld = 1; e_pc = trap_vec - (trap_vec % 4); end
          else ns = 1;
        end
        default: ns = 3;
      endcase
      checks++;
      if ({st, pc_ld, wv, mis, base} !== {2'(m_s), e_ld, e_wv, e_mis, m_b}) begin
        failures++;
        $display("FAIL rand_outputs iter=%0d got st=%0d ld=%0b wv=%h mis=%0b base=%h exp st=%0d ld=%0b wv=%h mis=%0b base=%h",
                 i, st, pc_ld, wv, mis, base, m_s, e_ld, e_wv, e_mis, m_b);
      end
      if (e_ld) begin
        checks++;
        if (pc_in !== e_pc) begin
          failures++; $display("FAIL rand_pc_in iter=%0d got pc=%h exp pc=%h", i, pc_in, e_pc);
        end
      end
      if (rst_n) begin
        if (e_ld) m_b = e_pc;
        m_s = ns;
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_advance();
    test_trap_over_branch();
    test_misalign();
    test_stall_halt();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
